booth_mul_scheduler: RTL and testbench

//  Shares one booth multiplier instance between NREQ requesters with round-robin arbitration.

---
 rtl/booth_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 38 +++
 rtl/booth_mul_scheduler.sv | 131 +++++++++++++
 tb/tb_booth_mul_scheduler.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the booth multiplier scheduler: FSM encoding,
// width helper and the default watchdog limit.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int TIMEOUT_DEFAULT = 64;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: rotates the request vector so the slot
// after the pointer is at bit 0, takes the lowest set bit, rotates the index back.
module rr_arbiter
  import booth_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  logic [IDW:0]      w_shift;
  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [IDW-1:0]    w_pos;
  logic [IDW:0]      w_sum;

  always_comb begin
    w_shift = {1'b0, i_ptr} + (IDW+1)'(1);
    w_dbl   = {i_req, i_req} >> w_shift;
    w_rot   = w_dbl[NREQ-1:0];
    w_pos   = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (w_rot[j]) w_pos = IDW'(j);
    end
    // The sum can reach 2*NREQ-1, so a single wrap subtraction suffices
    w_sum = {1'b0, i_ptr} + (IDW+1)'(1) + {1'b0, w_pos};
    if (w_sum >= (IDW+1)'(NREQ)) w_sum = w_sum - (IDW+1)'(NREQ);
    o_idx   = w_sum[IDW-1:0];
    o_any   = |i_req;
    o_grant = o_any ? (NREQ'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/booth_mul_scheduler.sv
// Shares one booth multiplier between NREQ requesters: round-robin grant,
// operand latch, start pulse, guarded Done capture, watchdog and response port.
module booth_mul_scheduler
  import booth_pkg::*;
#(
  parameter int N       = 8,
  parameter int NREQ    = 4,
  parameter int IDW     = clog2(NREQ),
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ*N-1:0] i_mplier_in,
  input  logic [NREQ*N-1:0] i_mcand_in,
  output logic [NREQ-1:0]   o_grant,
  output logic              o_mul_start,
  output logic [N-1:0]      o_mul_mplier,
  output logic [N-1:0]      o_mul_mcand,
  input  logic              i_mul_done,
  input  logic [2*N-1:0]    i_mul_product,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [IDW-1:0]    o_rsp_id,
  output logic [2*N-1:0]    o_rsp_product,
  output logic              o_rsp_err,
  output logic              o_busy
);

  localparam int WDW = clog2(TIMEOUT);

  state_t          r_state, w_state_next;
  logic [IDW-1:0]  r_ptr, r_rsp_id, w_win_idx;
  logic [NREQ-1:0] w_win_onehot;
  logic            w_any, w_take, w_capture, w_abort;
  logic [N-1:0]    r_mplier, r_mcand;
  logic [2*N-1:0]  r_rsp_product;
  logic            r_rsp_err, r_armed;
  logic [WDW-1:0]  r_wdog;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_grant (w_win_onehot),
    .o_idx   (w_win_idx),
    .o_any   (w_any)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_take       = 1'b0;
    w_capture    = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_take       = 1'b1;
          w_state_next = ISSUE;
        end
      end
      ISSUE: w_state_next = WAIT;
      // Only a Done that follows an observed low level belongs to this op
      WAIT: begin
        if (r_armed && i_mul_done) begin
          w_capture    = 1'b1;
          w_state_next = RESP;
        end else if (r_wdog == WDW'(TIMEOUT - 1)) begin
          w_abort      = 1'b1;
          w_state_next = RESP;
        end
      end
      RESP: begin
        if (i_rsp_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_ptr         <= IDW'(NREQ - 1);
      r_rsp_id      <= '0;
      r_mplier      <= '0;
      r_mcand       <= '0;
      r_rsp_product <= '0;
      r_rsp_err     <= 1'b0;
      r_armed       <= 1'b0;
      r_wdog        <= '0;
    end else begin
      if (w_take) begin
        r_ptr    <= w_win_idx;
        r_rsp_id <= w_win_idx;
        r_mplier <= i_mplier_in[w_win_idx*N +: N];
        r_mcand  <= i_mcand_in[w_win_idx*N +: N];
      end
      if (r_state == ISSUE) begin
        r_armed <= 1'b0;
        r_wdog  <= '0;
      end
      if (r_state == WAIT) begin
        if (!i_mul_done) r_armed <= 1'b1;
        if (w_capture) begin
          r_rsp_product <= i_mul_product;
          r_rsp_err     <= 1'b0;
        end else if (w_abort) begin
          r_rsp_product <= '0;
          r_rsp_err     <= 1'b1;
        end else begin
          r_wdog <= r_wdog + 1'b1;
        end
      end
    end
  end

  // Grant is combinational so that the accepting edge is the one that latches operands
  assign o_grant       = (w_take && !i_reset) ? w_win_onehot : '0;
  assign o_mul_start   = (r_state == ISSUE);
  assign o_mul_mplier  = r_mplier;
  assign o_mul_mcand   = r_mcand;
  assign o_rsp_valid   = (r_state == RESP);
  assign o_rsp_id      = r_rsp_id;
  assign o_rsp_product = r_rsp_product;
  assign o_rsp_err     = r_rsp_err;
  assign o_busy        = (r_state != IDLE);

endmodule

// File: tb/tb_booth_mul_scheduler.sv
// Self-checking bench for booth_mul_scheduler with a behavioural multiplier
// (6-cycle Done, optional stale-Done and hang modes) and a round-robin reference.
module tb_booth_mul_scheduler;

  localparam int N = 8;
  localparam int NREQ = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] mplierIn = '0;
  logic [31:0] mcandIn = '0;
  logic [3:0]  grant;
  logic        mulStart;
  logic [7:0]  mulMplier, mulMcand;
  logic        mulDone = 1'b0;
  logic [15:0] mulProduct = '0;
  logic        rspValid;
  logic        rspReady = 1'b0;
  logic [1:0]  rspId;
  logic [15:0] rspProduct;
  logic        rspErr;
  logic        busy;
  logic [41:0] allOut;

  int checks = 0;
  int fails = 0;
  int modelPtr = 3;
  int mulMode = 0;
  int mulCnt = -1;
  int staleHold = 0;
  int startCount = 0;
  logic [7:0] opA = '0, opB = '0;

  booth_mul_scheduler #(.N(N), .NREQ(NREQ), .TIMEOUT(64)) dut (
    .i_clock(clock), .i_reset(reset), .i_req(req),
    .i_mplier_in(mplierIn), .i_mcand_in(mcandIn),
    .o_grant(grant), .o_mul_start(mulStart),
    .o_mul_mplier(mulMplier), .o_mul_mcand(mulMcand),
    .i_mul_done(mulDone), .i_mul_product(mulProduct),
    .o_rsp_valid(rspValid), .i_rsp_ready(rspReady),
    .o_rsp_id(rspId), .o_rsp_product(rspProduct), .o_rsp_err(rspErr),
    .o_busy(busy)
  );

  assign allOut = {grant, mulStart, mulMplier, mulMcand, rspValid, rspId, rspProduct, rspErr, busy};

  always #5 clock = ~clock;

  function automatic logic [15:0] model_mul(input logic [7:0] a, input logic [7:0] b);
    int ia, ib;
    ia = int'($signed(a));
    ib = int'($signed(b));
    return 16'(ia * ib);
  endfunction

  function automatic int model_pick(input logic [3:0] r, input int ptr);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // Multiplier model: mode 0 normal, 1 keeps the old Done into the first WAIT cycle, 2 never finishes
  always @(negedge clock) begin
    if (mulStart) begin
      opA    <= mulMplier;
      opB    <= mulMcand;
      mulCnt <= (mulMode == 2) ? -1 : 6;
      if (mulMode == 1) begin
        staleHold  <= 2;
        mulProduct <= 16'hDEAD;
      end else begin
        mulDone    <= 1'b0;
        mulProduct <= 16'hBAD0;
      end
    end else begin
      if (staleHold == 1) mulDone <= 1'b0;
      if (staleHold > 0) staleHold <= staleHold - 1;
      if (mulCnt > 0) begin
        mulCnt <= mulCnt - 1;
        if (mulCnt == 1) begin
          mulDone    <= 1'b1;
          mulProduct <= model_mul(opA, opB);
        end
      end
    end
  end

  always @(posedge clock) if (mulStart) startCount <= startCount + 1;

  task automatic wait_grant(output logic [3:0] g, output bit ok);
    g = '0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (grant != 4'b0) begin
        g = grant;
        ok = 1'b1;
        return;
      end
      @(negedge clock);
    end
  endtask

  task automatic wait_rsp(output int cyc, output bit ok);
    cyc = 0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      cyc++;
      if (rspValid) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    req = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    modelPtr = 3;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    checks++;
    if (allOut !== '0) begin fails++; $display("[TB] FAIL reset_outputs: got %h expected 0", allOut); end
    req = 4'b1111;
    #1;
    checks++;
    if (grant !== 4'b0) begin fails++; $display("[TB] FAIL reset_grant_gated: got %b expected 0000", grant); end
    req = '0;
    reset = 1'b0;
    modelPtr = 3;
    @(negedge clock);
  endtask

  task automatic test_single();
    logic [3:0] g; bit ok; int cyc; int s0;
    mplierIn = '0; mcandIn = '0;
    mplierIn[7:0] = 8'd7;
    mcandIn[7:0] = 8'hFD;
    rspReady = 1'b1;
    s0 = startCount;
    req = 4'b0001;
    wait_grant(g, ok);
    checks++;
    if (!ok || g !== 4'b0001) begin fails++; $display("[TB] FAIL single_grant: got %b expected 0001", g); end
    modelPtr = 0;
    @(posedge clock); #1; req = '0;
    wait_rsp(cyc, ok);
    checks++;
    if (!ok || rspId !== 2'd0 || rspProduct !== 16'hFFEB || rspErr !== 1'b0) begin
      fails++; $display("[TB] FAIL single_rsp: got id=%0d p=%h err=%b expected id=0 p=ffeb err=0", rspId, rspProduct, rspErr);
    end
    checks++;
    if (cyc != 8) begin fails++; $display("[TB] FAIL single_latency: got %0d expected 8", cyc); end
    checks++;
    if (startCount - s0 != 1) begin fails++; $display("[TB] FAIL single_start_pulses: got %0d expected 1", startCount - s0); end
    @(negedge clock);
    checks++;
    if (rspValid !== 1'b0 || busy !== 1'b0) begin fails++; $display("[TB] FAIL single_idle: got valid=%b busy=%b expected 0 0", rspValid, busy); end
  endtask

  task automatic test_round_robin();
    logic [3:0] g; bit ok; int cyc; int w; logic [15:0] expP; logic busyAtGrant;
    apply_reset();
    rspReady = 1'b1;
    req = 4'b1111;
    for (int op = 0; op < 8; op++) begin
      mplierIn = $urandom; mcandIn = $urandom;
      w = model_pick(req, modelPtr);
      wait_grant(g, ok);
      busyAtGrant = busy;
      checks++;
      if (!ok || g !== 4'(1 << w)) begin fails++; $display("[TB] FAIL rr_grant op%0d: got %b expected %b", op, g, 4'(1 << w)); end
      checks++;
      if (busyAtGrant !== 1'b0) begin fails++; $display("[TB] FAIL rr_grant_busy op%0d: got busy=%b expected 0", op, busyAtGrant); end
      expP = model_mul(mplierIn[w*8 +: 8], mcandIn[w*8 +: 8]);
      modelPtr = w;
      @(posedge clock); #1;
      mplierIn = $urandom; mcandIn = $urandom;
      wait_rsp(cyc, ok);
      checks++;
      if (!ok || rspId !== 2'(w) || rspProduct !== expP || rspErr !== 1'b0) begin
        fails++; $display("[TB] FAIL rr_rsp op%0d: got id=%0d p=%h err=%b expected id=%0d p=%h err=0", op, rspId, rspProduct, rspErr, w, expP);
      end
    end
    req = '0;
    @(negedge clock);
  endtask

  task automatic test_backpressure();
    logic [3:0] g; bit ok; int cyc; int w; int w2; logic [15:0] expP; logic [3:0] req2; bit stable; bit quiet;
    rspReady = 1'b0;
    mplierIn = $urandom; mcandIn = $urandom;
    req = 4'(1 << $urandom_range(0, 3));
    w = model_pick(req, modelPtr);
    expP = model_mul(mplierIn[w*8 +: 8], mcandIn[w*8 +: 8]);
    wait_grant(g, ok);
    modelPtr = w;
    @(posedge clock); #1; req = '0;
    wait_rsp(cyc, ok);
    req2 = 4'($urandom_range(1, 15));
    req = req2;
    stable = 1'b1; quiet = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock); #1;
      if (rspValid !== 1'b1 || rspId !== 2'(w) || rspProduct !== expP || rspErr !== 1'b0) stable = 1'b0;
      if (grant !== 4'b0 || mulStart !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!ok || !stable) begin fails++; $display("[TB] FAIL bp_hold: got id=%0d p=%h valid=%b expected id=%0d p=%h valid=1", rspId, rspProduct, rspValid, w, expP); end
    checks++;
    if (!quiet) begin fails++; $display("[TB] FAIL bp_quiet: got grant or start during RESP, expected none"); end
    rspReady = 1'b1;
    w2 = model_pick(req2, modelPtr);
    expP = model_mul(mplierIn[w2*8 +: 8], mcandIn[w2*8 +: 8]);
    @(negedge clock); #1;
    checks++;
    if (rspValid !== 1'b0 || busy !== 1'b0) begin fails++; $display("[TB] FAIL bp_release: got valid=%b busy=%b expected 0 0", rspValid, busy); end
    checks++;
    if (grant !== 4'(1 << w2)) begin fails++; $display("[TB] FAIL bp_next_grant: got %b expected %b", grant, 4'(1 << w2)); end
    modelPtr = w2;
    @(posedge clock); #1; req = '0;
    wait_rsp(cyc, ok);
    checks++;
    if (!ok || rspId !== 2'(w2) || rspProduct !== expP) begin fails++; $display("[TB] FAIL bp_next_rsp: got id=%0d p=%h expected id=%0d p=%h", rspId, rspProduct, w2, expP); end
    req = '0;
    @(negedge clock);
  endtask

  task automatic test_stale_done();
    logic [3:0] g; bit ok; int cyc; int w; logic [15:0] expP;
    mulMode = 1;
    rspReady = 1'b1;
    mplierIn = $urandom; mcandIn = $urandom;
    req = 4'(1 << $urandom_range(0, 3));
    w = model_pick(req, modelPtr);
    expP = model_mul(mplierIn[w*8 +: 8], mcandIn[w*8 +: 8]);
    wait_grant(g, ok);
    modelPtr = w;
    @(posedge clock); #1; req = '0;
    wait_rsp(cyc, ok);
    checks++;
    if (!ok || rspProduct !== expP || rspErr !== 1'b0 || rspId !== 2'(w)) begin
      fails++; $display("[TB] FAIL stale_rsp: got id=%0d p=%h err=%b expected id=%0d p=%h err=0", rspId, rspProduct, rspErr, w, expP);
    end
    checks++;
    if (cyc != 8) begin fails++; $display("[TB] FAIL stale_latency: got %0d expected 8", cyc); end
    mulMode = 0;
    @(negedge clock);
  endtask

  task automatic test_timeout();
    logic [3:0] g; bit ok; int cyc; int w; logic [15:0] expP;
    mulMode = 2;
    rspReady = 1'b1;
    mplierIn = $urandom; mcandIn = $urandom;
    req = 4'(1 << $urandom_range(0, 3));
    w = model_pick(req, modelPtr);
    wait_grant(g, ok);
    modelPtr = w;
    @(posedge clock); #1; req = '0;
    wait_rsp(cyc, ok);
    checks++;
    if (!ok || rspErr !== 1'b1 || rspProduct !== 16'h0 || rspId !== 2'(w)) begin
      fails++; $display("[TB] FAIL timeout_rsp: got id=%0d p=%h err=%b expected id=%0d p=0000 err=1", rspId, rspProduct, rspErr, w);
    end
    checks++;
    if (cyc != 66) begin fails++; $display("[TB] FAIL timeout_latency: got %0d expected 66", cyc); end
    mulMode = 0;
    @(negedge clock);
    mplierIn = $urandom; mcandIn = $urandom;
    req = 4'(1 << $urandom_range(0, 3));
    w = model_pick(req, modelPtr);
    expP = model_mul(mplierIn[w*8 +: 8], mcandIn[w*8 +: 8]);
    wait_grant(g, ok);
    modelPtr = w;
    @(posedge clock); #1; req = '0;
    wait_rsp(cyc, ok);
    checks++;
    if (!ok || rspErr !== 1'b0 || rspProduct !== expP) begin fails++; $display("[TB] FAIL timeout_recover: got p=%h err=%b expected p=%h err=0", rspProduct, rspErr, expP); end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    logic [3:0] g; bit ok; int cyc; int r; logic [15:0] expP;
    rspReady = 1'b1;
    r = $urandom_range(0, 3);
    req = 4'(1 << r);
    for (int op = 0; op < 3; op++) begin
      mplierIn = $urandom; mcandIn = $urandom;
      expP = model_mul(mplierIn[r*8 +: 8], mcandIn[r*8 +: 8]);
      wait_grant(g, ok);
      checks++;
      if (!ok || g !== 4'(1 << r)) begin fails++; $display("[TB] FAIL b2b_grant op%0d: got %b expected %b", op, g, 4'(1 << r)); end
      modelPtr = r;
      @(posedge clock); #1;
      wait_rsp(cyc, ok);
      checks++;
      if (!ok || rspProduct !== expP || rspId !== 2'(r)) begin fails++; $display("[TB] FAIL b2b_rsp op%0d: got id=%0d p=%h expected id=%0d p=%h", op, rspId, rspProduct, r, expP); end
    end
    req = '0;
    @(negedge clock);
  endtask

  task automatic test_random();
    logic [3:0] g; bit ok; int cyc; int w; logic [15:0] expP;
    for (int op = 0; op < 10; op++) begin
      rspReady = 1'b0;
      mplierIn = $urandom; mcandIn = $urandom;
      req = 4'($urandom_range(1, 15));
      w = model_pick(req, modelPtr);
      expP = model_mul(mplierIn[w*8 +: 8], mcandIn[w*8 +: 8]);
      wait_grant(g, ok);
      checks++;
      if (!ok || g !== 4'(1 << w)) begin fails++; $display("[TB] FAIL rand_grant op%0d: got %b expected %b", op, g, 4'(1 << w)); end
      modelPtr = w;
      @(posedge clock); #1; req = '0;
      wait_rsp(cyc, ok);
      checks++;
      if (!ok || rspId !== 2'(w) || rspProduct !== expP || rspErr !== 1'b0) begin
        fails++; $display("[TB] FAIL rand_rsp op%0d: got id=%0d p=%h err=%b expected id=%0d p=%h err=0", op, rspId, rspProduct, rspErr, w, expP);
      end
      repeat ($urandom_range(0, 3)) @(negedge clock);
      rspReady = 1'b1;
      @(negedge clock);
    end
  endtask

  task automatic test_reset_midop();
    logic [3:0] g; bit ok; int cyc; bit idle; logic [15:0] expP;
    rspReady = 1'b1;
    mplierIn = $urandom; mcandIn = $urandom;
    req = 4'b0010;
    wait_grant(g, ok);
    @(posedge clock); #1; req = '0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (allOut !== '0) begin fails++; $display("[TB] FAIL reset_in_wait: got %h expected 0", allOut); end
    reset = 1'b0;
    modelPtr = 3;
    idle = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (busy !== 1'b0 || rspValid !== 1'b0) idle = 1'b0;
    end
    checks++;
    if (!idle) begin fails++; $display("[TB] FAIL reset_late_done: got busy=%b valid=%b expected 0 0", busy, rspValid); end
    rspReady = 1'b0;
    req = 4'b0010;
    wait_grant(g, ok);
    @(posedge clock); #1; req = '0;
    wait_rsp(cyc, ok);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (!ok || allOut !== '0) begin fails++; $display("[TB] FAIL reset_in_resp: got %h expected 0", allOut); end
    reset = 1'b0;
    modelPtr = 3;
    rspReady = 1'b1;
    mplierIn = $urandom; mcandIn = $urandom;
    req = 4'b0101;
    expP = model_mul(mplierIn[7:0], mcandIn[7:0]);
    wait_grant(g, ok);
    checks++;
    if (!ok || g !== 4'(1 << model_pick(4'b0101, modelPtr))) begin fails++; $display("[TB] FAIL reset_ptr_grant: got %b expected 0001", g); end
    modelPtr = 0;
    @(posedge clock); #1; req = '0;
    wait_rsp(cyc, ok);
    checks++;
    if (!ok || rspId !== 2'd0 || rspProduct !== expP) begin fails++; $display("[TB] FAIL reset_after_rsp: got id=%0d p=%h expected id=0 p=%h", rspId, rspProduct, expP); end
    @(negedge clock);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_stale_done();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
